// File: rtl/rv_skid_stage.sv
// rv_skid_stage: valid/ready register stage with a one-entry skid buffer.
// Forward (data/valid) and backward (ready) paths are both registered, so
// in_ready never depends combinationally on out_ready.
// Optional build macro RV_SKID_STALL_CNT_EN adds a 16-bit saturating
// stall_cnt output counting cycles with out_valid=1 and out_ready=0.
module rv_skid_stage #(
    parameter int unsigned WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef RV_SKID_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             in_fire;
    logic             out_fire;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL);
    assign out_data  = main_data_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Next-state and data-load selection; flush overrides the handshake
    // but leaves the data registers untouched.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_data_d = in_data;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_d = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end else if (in_fire) begin
                        skid_data_d = in_data;
                        state_d     = FULL;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_data_d = skid_data_q;
                        state_d     = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

`ifdef RV_SKID_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt = stall_cnt_q;

    // Saturating stall counter; only rst clears it, flush does not.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`else
    // No stall counter in this build.
`endif

endmodule

// File: tb/tb_rv_skid_stage.sv
// Directed, table-driven bench for rv_skid_stage (WIDTH=17).
module tb_rv_skid_stage;

    localparam int unsigned W = 17;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
`ifdef RV_SKID_STALL_CNT_EN
    logic [15:0]  stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    rv_skid_stage #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef RV_SKID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         flush;
        logic         in_valid;
        logic [W-1:0] in_data;
        logic         out_ready;
        logic         exp_out_valid;
        logic         exp_in_ready;
        logic [W-1:0] exp_out_data;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input int idx,
                         input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic iv,
                         input logic [W-1:0] d, input logic ordy);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    initial begin
        //                 rst  fl   iv   in_data     ordy  ov   ir   out_data
        // Reset with a payload offered: nothing captured.
        vq.push_back('{1'b1,1'b0,1'b1,17'h1ABCD,1'b0, 1'b0,1'b1,17'h00000});
        vq.push_back('{1'b1,1'b0,1'b1,17'h1ABCD,1'b0, 1'b0,1'b1,17'h00000});
        vq.push_back('{1'b0,1'b0,1'b0,17'h1ABCD,1'b1, 1'b0,1'b1,17'h00000});
        // Streaming with out_ready=1.
        vq.push_back('{1'b0,1'b0,1'b1,17'h00001,1'b1, 1'b1,1'b1,17'h00001});
        vq.push_back('{1'b0,1'b0,1'b1,17'h00002,1'b1, 1'b1,1'b1,17'h00002});
        vq.push_back('{1'b0,1'b0,1'b1,17'h00003,1'b1, 1'b1,1'b1,17'h00003});
        vq.push_back('{1'b0,1'b0,1'b0,17'h00000,1'b1, 1'b0,1'b1,17'h00003});
        // Backpressure into the skid, then drain in order.
        vq.push_back('{1'b0,1'b0,1'b1,17'h0AAAA,1'b0, 1'b1,1'b1,17'h0AAAA});
        vq.push_back('{1'b0,1'b0,1'b1,17'h15555,1'b0, 1'b1,1'b0,17'h0AAAA});
        vq.push_back('{1'b0,1'b0,1'b0,17'h00000,1'b0, 1'b1,1'b0,17'h0AAAA});
        vq.push_back('{1'b0,1'b0,1'b0,17'h00000,1'b1, 1'b1,1'b1,17'h15555});
        vq.push_back('{1'b0,1'b0,1'b0,17'h00000,1'b1, 1'b0,1'b1,17'h15555});
        // Flush from FULL with a payload offered.
        vq.push_back('{1'b0,1'b0,1'b1,17'h00100,1'b0, 1'b1,1'b1,17'h00100});
        vq.push_back('{1'b0,1'b0,1'b1,17'h00200,1'b0, 1'b1,1'b0,17'h00100});
        vq.push_back('{1'b0,1'b1,1'b1,17'h00077,1'b0, 1'b0,1'b1,17'h00100});
        vq.push_back('{1'b0,1'b0,1'b0,17'h00000,1'b0, 1'b0,1'b1,17'h00100});
        // Flush in ONE with concurrent in_fire and out_fire.
        vq.push_back('{1'b0,1'b0,1'b1,17'h00055,1'b0, 1'b1,1'b1,17'h00055});
        vq.push_back('{1'b0,1'b1,1'b1,17'h00077,1'b1, 1'b0,1'b1,17'h00055});
        vq.push_back('{1'b0,1'b0,1'b0,17'h00000,1'b0, 1'b0,1'b1,17'h00055});
        // Simultaneous in/out in ONE.
        vq.push_back('{1'b0,1'b0,1'b1,17'h00010,1'b0, 1'b1,1'b1,17'h00010});
        vq.push_back('{1'b0,1'b0,1'b1,17'h00020,1'b1, 1'b1,1'b1,17'h00020});
        vq.push_back('{1'b0,1'b0,1'b0,17'h00000,1'b1, 1'b0,1'b1,17'h00020});
        // in_valid held while in_ready=0; taken on first ready cycle.
        vq.push_back('{1'b0,1'b0,1'b1,17'h00301,1'b0, 1'b1,1'b1,17'h00301});
        vq.push_back('{1'b0,1'b0,1'b1,17'h00302,1'b0, 1'b1,1'b0,17'h00301});
        vq.push_back('{1'b0,1'b0,1'b1,17'h00303,1'b0, 1'b1,1'b0,17'h00301});
        vq.push_back('{1'b0,1'b0,1'b1,17'h00303,1'b1, 1'b1,1'b1,17'h00302});
        vq.push_back('{1'b0,1'b0,1'b1,17'h00303,1'b0, 1'b1,1'b0,17'h00302});
        vq.push_back('{1'b0,1'b0,1'b0,17'h00000,1'b1, 1'b1,1'b1,17'h00303});
        vq.push_back('{1'b0,1'b0,1'b0,17'h00000,1'b1, 1'b0,1'b1,17'h00303});
        // Reset mid-transfer zeroes data and drops the offered payload.
        vq.push_back('{1'b0,1'b0,1'b1,17'h0F0F0,1'b0, 1'b1,1'b1,17'h0F0F0});
        vq.push_back('{1'b1,1'b0,1'b1,17'h1AAAA,1'b0, 1'b0,1'b1,17'h00000});
        vq.push_back('{1'b0,1'b0,1'b0,17'h00000,1'b0, 1'b0,1'b1,17'h00000});

        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        @(posedge clk);
        #1;

        for (int unsigned i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].flush, vq[i].in_valid, vq[i].in_data, vq[i].out_ready);
            @(posedge clk);
            #1;
            check("out_valid", int'(i), W'(out_valid), W'(vq[i].exp_out_valid));
            check("in_ready",  int'(i), W'(in_ready),  W'(vq[i].exp_in_ready));
            check("out_data",  int'(i), out_data,      vq[i].exp_out_data);
        end

`ifdef RV_SKID_STALL_CNT_EN
        // Stall counter: 5 stalled cycles, survives flush, cleared by rst.
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        @(posedge clk); #1;
        check("stall_cnt_rst0", 0, W'(stall_cnt), W'(16'd0));
        drive(1'b0, 1'b0, 1'b1, 17'h00005, 1'b0);
        @(posedge clk); #1;
        check("stall_cnt_load", 0, W'(stall_cnt), W'(16'd0));
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        for (int unsigned i = 0; i < 5; i++) begin
            @(posedge clk);
        end
        #1;
        check("stall_cnt_5", 0, W'(stall_cnt), W'(16'd5));
        drive(1'b0, 1'b1, 1'b0, '0, 1'b1);
        @(posedge clk); #1;
        check("stall_cnt_flush", 0, W'(stall_cnt), W'(16'd5));
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        @(posedge clk); #1;
        check("stall_cnt_idle", 0, W'(stall_cnt), W'(16'd5));
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        @(posedge clk); #1;
        check("stall_cnt_rst", 0, W'(stall_cnt), W'(16'd0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_skid_stage.md
Name: rv_skid_stage

Overview:
- Valid/ready pipeline register stage with a one-entry skid buffer, for carrying WIDTH-bit payloads between SweRV pipeline blocks.
- Accepts data from an upstream producer and presents it registered to a downstream consumer.
- Fully registers both the forward path and the backpressure path. in_ready never depends combinationally on out_ready.
- Complements the plain always-enabled flop register for interfaces that need stall capability.

Parameters:
WIDTH, 17, payload width in bits (min 1)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
flush  input  1  synchronous discard of all buffered entries
in_valid  input  1  upstream payload valid
in_ready  output  1  stage can accept a payload this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  downstream payload valid
out_ready  input  1  downstream accepts the payload this cycle
out_data  output  WIDTH  downstream payload

Behaviour:
- Reset: one clock, rst is synchronous and active-high. While rst=1 at a rising edge:
  - state<=EMPTY
  - main_data<=0, skid_data<=0
  - Resulting outputs: out_valid=0, in_ready=1, out_data=0
- Priority of events: rst > flush > handshake.
- Transfer definitions:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- Registered outputs:
  - out_valid = (state != EMPTY)
  - in_ready = (state != FULL)
  - out_data = main_data
  - All three are functions of registered state only.
- States: EMPTY (0 entries), ONE (main valid), FULL (main and skid valid).
- Transitions (no flush):
  - EMPTY:
    - in_fire -> main_data<=in_data, go to ONE
    - otherwise stay in EMPTY
  - ONE:
    - in_fire & out_fire -> main_data<=in_data, stay in ONE
    - out_fire only -> go to EMPTY
    - in_fire only -> skid_data<=in_data, go to FULL
    - neither -> hold
  - FULL (in_ready=0, so no input is accepted):
    - out_fire -> main_data<=skid_data, go to ONE
    - otherwise hold
- Latency: a payload accepted at edge N is visible on out_data/out_valid after edge N (one cycle). There is no combinational in->out path.
- Throughput: one payload per cycle when out_ready is held at 1.
- Ordering: strict FIFO order. A skid entry always drains before any newer payload.
- Data registers hold their value when not loaded. Stale data is not cleared on dequeue.
- flush=1 at an edge:
  - state<=EMPTY
  - A concurrent in_fire is discarded.
  - A concurrent out_fire is treated as completed: the consumer sampled the payload, and the producer must not retry it.
  - Data registers are not cleared.
- Reset mid-transfer: same as flush, and also zeroes the data registers. A payload offered during the reset cycle is dropped.
- in_data is ignored when in_valid=0. out_data is don't-care when out_valid=0, but must equal the last loaded main_data.
- in_valid held high while in_ready=0 is legal. The payload is taken on the first cycle in_ready=1.

Optional Feature:
- Macro: RV_SKID_STALL_CNT_EN.
- When defined, the block adds output port stall_cnt (16 bits).
  - Increments at every edge where out_valid=1 & out_ready=0.
  - Saturates at 16'hFFFF.
  - Reset to 0 by rst only; flush does not clear it.
- When not defined, the port and counter do not exist and behaviour is otherwise identical.

Test Plan:
1. Reset behaviour:
   - Stimulus: assert rst for 2 cycles with in_valid=1, in_data=17'h1ABCD.
   - Required: out_valid=0, in_ready=1, out_data=0 after release; no payload captured.
2. Streaming:
   - Stimulus: out_ready=1; send 17'h00001,17'h00002,17'h00003 on consecutive cycles.
   - Required: out_data shows the same sequence one cycle later, out_valid continuous, in_ready stays 1.
3. Backpressure and skid:
   - Stimulus: out_ready=0; send 17'h0AAAA then 17'h15555.
   - Required: FULL with in_ready=0 and out_data=17'h0AAAA held.
   - Then set out_ready=1. Required: 17'h0AAAA, then 17'h15555 on consecutive cycles, in_ready=1 again after the first drain.
4. Flush:
   - Stimulus: fill to FULL, then assert flush with in_valid=1, in_data=17'h00077.
   - Required: next cycle out_valid=0, in_ready=1; 17'h00077 never appears.
5. Simultaneous in/out in ONE:
   - Stimulus: main holds 17'h00010; in_fire 17'h00020 and out_fire in the same cycle.
   - Required: stays ONE, out_data=17'h00020, skid unused (in_ready stays 1).
6. RV_SKID_STALL_CNT_EN:
   - Stimulus: hold one payload with out_ready=0 for 5 cycles.
   - Required: stall_cnt=5.
   - Then assert flush. Required: stall_cnt still 5. Then assert rst. Required: stall_cnt=0.
